gray_ptr_sync_rd: RTL and testbench
===================================

Name: gray_ptr_sync_rd

Overview:
- Read-domain receiver for the async FIFO write pointer.
- Passes the Gray-coded write pointer through a parametrised flop chain, then registers a binary copy.
- Computes the registered fill level and empty flag against the local read pointer.
- Flags Gray-coding violations, which indicate a CDC fault or a corrupted pointer.
- Replaces the fixed two-flop write-to-read synchroniser in the FIFO read side.

Parameters:
- ADDRSIZE, 4, FIFO address width; pointers are ADDRSIZE+1 bits; depth = 2**ADDRSIZE.
- SYNC_STAGES, 2, number of synchroniser flops; legal range 2..4; elaboration error outside that range.

Ports:
- rd_clk  input  1  read-domain clock.
- rrst  input  1  asynchronous active-high reset.
- wptr_gray  input  ADDRSIZE+1  Gray write pointer from the write domain (asynchronous).
- rptr_bin  input  ADDRSIZE+1  binary read pointer, synchronous to rd_clk.
- err_clr  input  1  clears sticky error flags.
- rq_wptr_gray  output  ADDRSIZE+1  synchronised Gray pointer (last sync stage).
- rq_wptr_bin  output  ADDRSIZE+1  registered binary decode of rq_wptr_gray.
- rq_valid  output  1  outputs meaningful (flush complete).
- rq_upd  output  1  one-cycle pulse, rq_wptr_bin changed this cycle.
- fill_level  output  ADDRSIZE+1  registered words available to read.
- rempty  output  1  registered empty flag.
- gray_err  output  1  sticky: synchronised pointer moved by more than one Gray bit.
- fill_err  output  1  sticky: fill_level exceeded depth.

Behaviour:
- Reset (rrst high, asynchronous):
  - all sync stages, rq_wptr_gray, rq_wptr_bin, fill_level, rq_upd, gray_err, fill_err and the flush counter go to 0;
  - rq_valid goes to 0; rempty goes to 1.
- Sync chain:
  - stage[0] <= wptr_gray; stage[i] <= stage[i-1];
  - rq_wptr_gray = stage[SYNC_STAGES-1], latency SYNC_STAGES edges.
  - No logic between stages.
- Decode: rq_wptr_bin <= gray2bin(rq_wptr_gray), so latency is SYNC_STAGES+1 from input.
- Flush counter:
  - counts rd_clk edges after reset deassertion and saturates at SYNC_STAGES+1;
  - rq_valid is registered and asserts on the edge the counter reaches SYNC_STAGES+1;
  - it stays 1 until the next reset.
- rq_upd:
  - registered; 1 for exactly the cycle after the edge in which the new rq_wptr_bin differs from its previous value;
  - forced 0 while rq_valid is 0.
- Gray check:
  - on each edge with rq_valid=1, compare the new rq_wptr_gray with its previous value;
  - popcount(XOR) > 1 sets gray_err; 0 or 1 is legal.
- Fill:
  - fill_level <= rq_wptr_bin - rptr_bin, computed modulo 2**(ADDRSIZE+1), so pointer wrap-around is handled naturally;
  - rempty <= (rq_wptr_bin == rptr_bin) or !rq_valid.
  - Latency from rq_wptr_bin or rptr_bin change to fill_level/rempty: 1 cycle.
- fill_err: set when rq_valid and the computed fill exceeds 2**ADDRSIZE.
- Sticky flags: set and err_clr in the same cycle -> set wins (flag stays 1); err_clr alone clears on the next edge.
- Reset mid-operation: every state returns to its reset value immediately; the flush restarts; rq_upd and the error flags cannot fire until rq_valid reasserts.

Decomposition:
- Package gray_ptr_pkg:
  - function gray2bin, generic width via parameterised class or fixed max width with masking;
  - function popcount;
  - localparam SYNC_STAGES_MIN=2 and SYNC_STAGES_MAX=4.
- Sub-module cdc_sync_chain (WIDTH, STAGES):
  - pure flop chain with async active-high reset;
  - reusable for the read-to-write direction.

Test Plan:
1. Reset release, SYNC_STAGES=2, wptr_gray held 0 -> rq_valid rises on the 3rd rd_clk edge after deassertion; rempty=1 and fill_level=0 throughout.
2. Latency check, SYNC_STAGES=3:
   - step wptr_gray 0 -> 1 one cycle after rq_valid;
   - rq_wptr_gray=1 after 3 edges, rq_wptr_bin=1 after 4, rq_upd pulses for one cycle;
   - with rptr_bin=0, fill_level=1 and rempty=0 one cycle later.
3. Wrap-around, ADDRSIZE=4:
   - rptr_bin=5'd30, wptr_gray=gray(5'd2) -> fill_level=4, fill_err=0;
   - with rptr_bin=0 and wptr_gray=gray(17) -> fill_err=1 and stays set.
4. Gray violation: wptr_gray jumps 5'b00000 -> 5'b00011 -> gray_err=1 two edges after the jump reaches rq_wptr_gray; err_clr asserted with a new violation in the same cycle -> gray_err stays 1.
5. Mid-operation reset:
   - with fill_level=7, pulse rrst for half a cycle between edges;
   - outputs return to reset values without waiting for an edge;
   - rq_valid is 0 again for SYNC_STAGES+1 edges, and no rq_upd or errors appear during the flush.

Source files
------------

// File: rtl/gray_ptr_pkg.sv
// Shared helpers for Gray-pointer synchronisers: width-generic Gray decode,
// population count and the legal synchroniser depth range.
package gray_ptr_pkg;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;
    localparam int PTR_MAX_W       = 32;

    typedef logic [PTR_MAX_W-1:0] ptr_max_t;

    // Bits above 'width' are masked so callers can pass zero-extended pointers.
    function automatic ptr_max_t gray2bin(input ptr_max_t gray, input int width);
        ptr_max_t masked;
        ptr_max_t bin;
        masked = gray & ~(ptr_max_t'('1) << width);
        bin    = '0;
        for (int i = 0; i < PTR_MAX_W; i++) begin
            bin[i] = ^(masked >> i);
        end
        return bin;
    endfunction

    function automatic int unsigned popcount(input ptr_max_t value);
        int unsigned count;
        count = 0;
        for (int i = 0; i < PTR_MAX_W; i++) begin
            count += {31'b0, value[i]};
        end
        return count;
    endfunction

endpackage

// File: rtl/cdc_sync_chain.sv
// Plain multi-flop synchroniser with asynchronous active-high reset; no logic
// between stages, so it serves either FIFO pointer crossing direction.
module cdc_sync_chain
    import gray_ptr_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [STAGES];

    if (STAGES < SYNC_STAGES_MIN) begin : g_bad_stages
        $error("cdc_sync_chain: STAGES must be at least %0d", SYNC_STAGES_MIN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments make each stage take its predecessor's old value.
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/gray_ptr_sync_rd.sv
// Read-domain receiver for the async FIFO write pointer: synchronise, decode,
// derive fill level / empty, and flag pointer corruption.
module gray_ptr_sync_rd
    import gray_ptr_pkg::*;
#(
    parameter int ADDRSIZE    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              rd_clk,
    input  logic              rrst,
    input  logic [ADDRSIZE:0] wptr_gray,
    input  logic [ADDRSIZE:0] rptr_bin,
    input  logic              err_clr,
    output logic [ADDRSIZE:0] rq_wptr_gray,
    output logic [ADDRSIZE:0] rq_wptr_bin,
    output logic              rq_valid,
    output logic              rq_upd,
    output logic [ADDRSIZE:0] fill_level,
    output logic              rempty,
    output logic              gray_err,
    output logic              fill_err
);

    localparam int                PTR_W      = ADDRSIZE + 1;
    localparam logic [ADDRSIZE:0] DEPTH      = {1'b1, {ADDRSIZE{1'b0}}};
    localparam logic [2:0]        FLUSH_LAST = 3'(SYNC_STAGES);

    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
        $error("gray_ptr_sync_rd: SYNC_STAGES must be in %0d..%0d",
               SYNC_STAGES_MIN, SYNC_STAGES_MAX);
    end

    logic [ADDRSIZE:0] wbin_next;
    logic [ADDRSIZE:0] fill_next;
    logic [ADDRSIZE:0] gray_prev;
    logic              gray_viol;
    logic [2:0]        flush_cnt;

    cdc_sync_chain #(
        .WIDTH  (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (rd_clk),
        .rst (rrst),
        .d   (wptr_gray),
        .q   (rq_wptr_gray)
    );

    always_comb begin
        wbin_next = PTR_W'(gray2bin(ptr_max_t'(rq_wptr_gray), PTR_W));
        fill_next = rq_wptr_bin - rptr_bin;
    end

    // Flush covers the chain plus the decode register, so the first valid
    // cycle already carries a decoded pointer taken entirely after reset.
    always_ff @(posedge rd_clk or posedge rrst) begin
        if (rrst) begin
            flush_cnt <= '0;
            rq_valid  <= 1'b0;
        end else if (!rq_valid) begin
            flush_cnt <= flush_cnt + 3'd1;
            if (flush_cnt == FLUSH_LAST) begin
                rq_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge rd_clk or posedge rrst) begin
        if (rrst) begin
            rq_wptr_bin <= '0;
            rq_upd      <= 1'b0;
            fill_level  <= '0;
            rempty      <= 1'b1;
        end else begin
            rq_wptr_bin <= wbin_next;
            rq_upd      <= rq_valid && (wbin_next != rq_wptr_bin);
            fill_level  <= fill_next;
            rempty      <= (rq_wptr_bin == rptr_bin) || !rq_valid;
        end
    end

    // Violation is staged one cycle before the sticky flag; set beats clear.
    always_ff @(posedge rd_clk or posedge rrst) begin
        if (rrst) begin
            gray_prev <= '0;
            gray_viol <= 1'b0;
            gray_err  <= 1'b0;
            fill_err  <= 1'b0;
        end else begin
            gray_prev <= rq_wptr_gray;
            gray_viol <= rq_valid && (popcount(ptr_max_t'(rq_wptr_gray ^ gray_prev)) > 1);
            gray_err  <= gray_viol || (gray_err && !err_clr);
            fill_err  <= (rq_valid && (fill_next > DEPTH)) || (fill_err && !err_clr);
        end
    end

endmodule

// File: tb/tb_gray_ptr_sync_rd.sv
// Directed bench for gray_ptr_sync_rd: two instances (2 and 3 sync stages) share
// stimulus; expectations are queued with a due cycle and checked when it arrives.
module tb_gray_ptr_sync_rd;

    localparam int AW = 4;

    // Observation selectors: instance base + signal offset.
    localparam int A = 0, B = 8;
    localparam int GRAY = 0, BIN = 1, VALID = 2, UPD = 3, FILL = 4, EMPTY = 5, GERR = 6, FERR = 7;

    logic          rd_clk;
    logic          rrst;
    logic [AW:0]   wptr_gray;
    logic [AW:0]   rptr_bin;
    logic          err_clr;

    logic [AW:0]   a_gray, a_bin, a_fill, b_gray, b_bin, b_fill;
    logic          a_valid, a_upd, a_empty, a_gerr, a_ferr;
    logic          b_valid, b_upd, b_empty, b_gerr, b_ferr;

    gray_ptr_sync_rd #(.ADDRSIZE(AW), .SYNC_STAGES(2)) dut_a (
        .rd_clk       (rd_clk),
        .rrst         (rrst),
        .wptr_gray    (wptr_gray),
        .rptr_bin     (rptr_bin),
        .err_clr      (err_clr),
        .rq_wptr_gray (a_gray),
        .rq_wptr_bin  (a_bin),
        .rq_valid     (a_valid),
        .rq_upd       (a_upd),
        .fill_level   (a_fill),
        .rempty       (a_empty),
        .gray_err     (a_gerr),
        .fill_err     (a_ferr)
    );

    gray_ptr_sync_rd #(.ADDRSIZE(AW), .SYNC_STAGES(3)) dut_b (
        .rd_clk       (rd_clk),
        .rrst         (rrst),
        .wptr_gray    (wptr_gray),
        .rptr_bin     (rptr_bin),
        .err_clr      (err_clr),
        .rq_wptr_gray (b_gray),
        .rq_wptr_bin  (b_bin),
        .rq_valid     (b_valid),
        .rq_upd       (b_upd),
        .fill_level   (b_fill),
        .rempty       (b_empty),
        .gray_err     (b_gerr),
        .fill_err     (b_ferr)
    );

    initial rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    typedef struct {
        string       tag;
        int          sig;
        logic [31:0] exp;
        int          due;
    } sb_item_t;

    sb_item_t sb[$];
    int       cyc    = 0;
    int       checks = 0;
    int       errors = 0;

    function automatic logic [31:0] observe(input int sig);
        case (sig)
            A + GRAY:  return 32'(a_gray);
            A + BIN:   return 32'(a_bin);
            A + VALID: return 32'(a_valid);
            A + UPD:   return 32'(a_upd);
            A + FILL:  return 32'(a_fill);
            A + EMPTY: return 32'(a_empty);
            A + GERR:  return 32'(a_gerr);
            A + FERR:  return 32'(a_ferr);
            B + GRAY:  return 32'(b_gray);
            B + BIN:   return 32'(b_bin);
            B + VALID: return 32'(b_valid);
            B + UPD:   return 32'(b_upd);
            B + FILL:  return 32'(b_fill);
            B + EMPTY: return 32'(b_empty);
            B + GERR:  return 32'(b_gerr);
            B + FERR:  return 32'(b_ferr);
            default:   return 32'hdead_beef;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input string tag, input int sig, input logic [31:0] exp, input int delay);
        sb_item_t it;
        it.tag = tag;
        it.sig = sig;
        it.exp = exp;
        it.due = cyc + delay;
        sb.push_back(it);
    endtask

    // Advance one edge, sample 1 ns later, and retire every expectation due now.
    task automatic tick();
        @(posedge rd_clk);
        #1;
        cyc++;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                check(sb[i].tag, observe(sb[i].sig), sb[i].exp);
                sb.delete(i);
            end
        end
    endtask

    initial begin
        logic [31:0] rst_exp [8];
        rst_exp = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd0, 32'd0};

        rrst      = 1'b0;
        wptr_gray = '0;
        rptr_bin  = '0;
        err_clr   = 1'b0;
        #1 rrst = 1'b1;
        repeat (3) tick();

        // Reset release: valid on edge 3 (2 stages) / edge 4 (3 stages), empty throughout.
        rrst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            push("t1_a_valid", A + VALID, 32'(k >= 3), k);
            push("t1_b_valid", B + VALID, 32'(k >= 4), k);
            push("t1_a_empty", A + EMPTY, 32'd1, k);
            push("t1_a_fill",  A + FILL,  32'd0, k);
            push("t1_b_empty", B + EMPTY, 32'd1, k);
            push("t1_a_upd",   A + UPD,   32'd0, k);
        end
        repeat (5) tick();

        // Latency: gray after 3 edges, binary after 4, fill one cycle later.
        wptr_gray = 5'd1;
        push("t2_b_gray_early", B + GRAY,  32'd0, 2);
        push("t2_b_gray",       B + GRAY,  32'd1, 3);
        push("t2_b_bin_early",  B + BIN,   32'd0, 3);
        push("t2_b_bin",        B + BIN,   32'd1, 4);
        push("t2_b_upd",        B + UPD,   32'd1, 4);
        push("t2_b_upd_end",    B + UPD,   32'd0, 5);
        push("t2_b_fill_early", B + FILL,  32'd0, 4);
        push("t2_b_empty_early",B + EMPTY, 32'd1, 4);
        push("t2_b_fill",       B + FILL,  32'd1, 5);
        push("t2_b_empty",      B + EMPTY, 32'd0, 5);
        push("t2_a_gray",       A + GRAY,  32'd1, 2);
        push("t2_a_bin",        A + BIN,   32'd1, 3);
        repeat (6) tick();

        // Gray violation 00000 -> 00011, flagged two edges after reaching rq_wptr_gray.
        wptr_gray = 5'b00000;
        repeat (6) tick();
        wptr_gray = 5'b00011;
        push("t4_b_gray",      B + GRAY, 32'd3, 3);
        push("t4_b_gerr_pre",  B + GERR, 32'd0, 4);
        push("t4_b_gerr",      B + GERR, 32'd1, 5);
        push("t4_a_gerr_pre",  A + GERR, 32'd0, 3);
        push("t4_a_gerr",      A + GERR, 32'd1, 4);
        repeat (6) tick();

        // New violation with err_clr in the same cycle: set wins (b); clear alone (a).
        wptr_gray = 5'b00000;
        push("t4_a_gerr2", A + GERR, 32'd1, 4);
        repeat (4) tick();
        err_clr = 1'b1;
        push("t4_b_setwins",  B + GERR, 32'd1, 1);
        push("t4_a_cleared",  A + GERR, 32'd0, 1);
        tick();
        err_clr = 1'b0;
        push("t4_b_sticky",   B + GERR, 32'd1, 1);
        tick();

        // Wrap-around: wptr bin 2, rptr 30 -> fill 4.
        rptr_bin  = 5'd30;
        wptr_gray = 5'b00011;
        push("t3_fill_wrap0", B + FILL, 32'd2, 1);
        push("t3_bin",        B + BIN,  32'd2, 4);
        push("t3_upd",        B + UPD,  32'd1, 4);
        push("t3_fill_wrap",  B + FILL, 32'd4, 5);
        push("t3_empty",      B + EMPTY,32'd0, 5);
        push("t3_ferr_ok",    B + FERR, 32'd0, 5);
        repeat (5) tick();

        // Overfill: wptr bin 17, rptr 0 -> fill 17 > 16.
        rptr_bin  = 5'd0;
        wptr_gray = 5'b11001;
        push("t3_fill_pre",   B + FILL, 32'd2,  1);
        push("t3_ferr_pre",   B + FERR, 32'd0,  4);
        push("t3_bin17",      B + BIN,  32'd17, 4);
        push("t3_fill17",     B + FILL, 32'd17, 5);
        push("t3_ferr_set",   B + FERR, 32'd1,  5);
        repeat (5) tick();
        rptr_bin = 5'd1;
        push("t3_fill16",     B + FILL, 32'd16, 1);
        push("t3_ferr_stick", B + FERR, 32'd1,  2);
        repeat (2) tick();
        err_clr = 1'b1;
        push("t3_ferr_clr",   B + FERR, 32'd0, 1);
        push("t3_gerr_clr",   B + GERR, 32'd0, 1);
        tick();
        err_clr = 1'b0;
        push("t3_ferr_depth", B + FERR, 32'd0,  1);
        push("t3_fill_depth", B + FILL, 32'd16, 1);
        tick();

        // Mid-operation reset with fill 7 (errors also set beforehand).
        rptr_bin  = 5'd0;
        wptr_gray = 5'b00100;
        push("t5_fill7",   B + FILL,  32'd7, 5);
        push("t5_empty",   B + EMPTY, 32'd0, 5);
        push("t5_gerr_on", B + GERR,  32'd1, 5);
        push("t5_ferr_on", B + FERR,  32'd1, 5);
        repeat (5) tick();
        #2 rrst = 1'b1;
        #2;
        for (int s = 0; s < 8; s++) begin
            check($sformatf("t5_async_b_sig%0d", s), observe(B + s), rst_exp[s]);
            check($sformatf("t5_async_a_sig%0d", s), observe(A + s), rst_exp[s]);
        end
        #3 rrst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            push("t5_b_valid", B + VALID, 32'(k >= 4), k);
            push("t5_b_gerr",  B + GERR,  32'd0, k);
            push("t5_b_ferr",  B + FERR,  32'd0, k);
            if (k <= 3) begin
                push("t5_b_upd",   B + UPD,   32'd0, k);
                push("t5_a_valid", A + VALID, 32'(k >= 3), k);
            end
        end
        push("t5_b_empty_flush", B + EMPTY, 32'd1, 4);
        push("t5_b_fill_after",  B + FILL,  32'd7, 5);
        push("t5_b_empty_after", B + EMPTY, 32'd0, 5);
        repeat (6) tick();

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
